pipe_stage_skid: RTL and testbench

//  Parametrised IF/ID-class pipeline register with valid/ready handshake and a
//  one-entry skid buffer, so an upstream stage may run one cycle ahead of a

---
 rtl/pipe_stage_skid.sv | 168 ++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   IF/ID-class pipeline register carrying {pc, inst} with a valid/ready
//   handshake and a one-entry skid buffer. Because in_ready_o comes only from
//   registered state, the upstream stage can run one cycle ahead of a
//   downstream stall. The entry that arrives during that cycle is caught in
//   the skid register. Order is strictly FIFO. flush_i turns the stage into a
//   bubble. rst_i does the same and also clears the statistics counters.
//
//   Optional feature macro: PIPE_STAGE_STATS_EN
//     When it is defined, stall_cnt_o and flush_cnt_o are saturating counters.
//     When it is not defined, both ports are tied to 0 and no counter flops
//     exist.
//
// Ports
//   clk_i        clock, all state changes on posedge
//   rst_i        synchronous active-high reset (priority over everything)
//   flush_i      discard main and skid entries, output a bubble next cycle
//   stall_i      downstream not ready (out_ready = ~stall_i)
//   in_valid_i   upstream offers {pc_i, inst_i}
//   in_ready_o   stage can accept this cycle (state != FULL)
//   pc_i         upstream pc
//   inst_i       upstream instruction
//   out_valid_o  pc_o/inst_o hold a real entry
//   pc_o         held pc, 0 for a bubble
//   inst_o       held inst, NOP_INST for a bubble
//   stall_cnt_o  cycles with out_valid_o & stall_i
//   flush_cnt_o  cycles with flush_i asserted
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int                PC_W     = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [INST_W-1:0] inst_i,
    output logic              out_valid_o,
    output logic [PC_W-1:0]   pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q;
    logic [PC_W-1:0]   main_pc_q;
    logic [INST_W-1:0] main_inst_q;
    logic [PC_W-1:0]   skid_pc_q;
    logic [INST_W-1:0] skid_inst_q;

    logic accept;
    logic drain;

    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign accept      = in_valid_i & in_ready_o;
    assign drain       = out_valid_o & ~stall_i;

    // The main register drives the outputs directly. It is cleared to bubble
    // values every time the stage enters EMPTY, so an invalid output always
    // reads as {0, NOP_INST} and needs no output mux.
    assign pc_o   = main_pc_q;
    assign inst_o = main_inst_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            // An entry offered in this cycle is dropped, even with in_ready_o high.
            state_q     <= EMPTY;
            main_pc_q   <= '0;
            main_inst_q <= NOP_INST;
            skid_pc_q   <= '0;
            skid_inst_q <= NOP_INST;
        end else begin
            case (state_q)
                EMPTY: begin
                    // stall_i has no effect here: there is nothing to hold.
                    if (accept) begin
                        state_q     <= BUSY;
                        main_pc_q   <= pc_i;
                        main_inst_q <= inst_i;
                    end
                end
                BUSY: begin
                    if (accept && drain) begin
                        main_pc_q   <= pc_i;
                        main_inst_q <= inst_i;
                    end else if (accept) begin
                        // The downstream stalled after we had already said ready.
                        state_q     <= FULL;
                        skid_pc_q   <= pc_i;
                        skid_inst_q <= inst_i;
                    end else if (drain) begin
                        state_q     <= EMPTY;
                        main_pc_q   <= '0;
                        main_inst_q <= NOP_INST;
                    end
                end
                FULL: begin
                    if (drain) begin
                        state_q     <= BUSY;
                        main_pc_q   <= skid_pc_q;
                        main_inst_q <= skid_inst_q;
                        skid_pc_q   <= '0;
                        skid_inst_q <= NOP_INST;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    main_pc_q   <= '0;
                    main_inst_q <= NOP_INST;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        // Hold at all-ones instead of wrapping.
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid_o && stall_i) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
        if (flush_i) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
//   Scoreboard bench for pipe_stage_skid. The driver keeps its own occupancy
//   model and pushes every accepted {pc, inst} into exp_q. The monitor pops
//   from exp_q whenever the DUT drains an entry and compares it. The monitor
//   also checks bubble values whenever out_valid_o is low.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

    localparam int          PC_W   = 32;
    localparam int          INST_W = 32;
    localparam int          CNT_W  = 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          CMAX   = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_i, flush_i, stall_i, in_valid_i, in_ready_o, out_valid_o;
    logic [PC_W-1:0]   pc_i, pc_o;
    logic [INST_W-1:0] inst_i, inst_o;
    logic [CNT_W-1:0]  stall_cnt_o, flush_cnt_o;

    pipe_stage_skid #(
        .PC_W    (PC_W),
        .INST_W  (INST_W),
        .NOP_INST(NOP),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .stall_i    (stall_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .pc_i       (pc_i),
        .inst_i     (inst_i),
        .out_valid_o(out_valid_o),
        .pc_o       (pc_o),
        .inst_o     (inst_o),
        .stall_cnt_o(stall_cnt_o),
        .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    logic [63:0] exp_q[$];
    int          occ = 0;        // model occupancy: 0 EMPTY, 1 BUSY, 2 FULL
    int          s_exp = 0;
    int          f_exp = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0F00;
    endfunction

    // Called just after a posedge. Checks the registered state against the
    // model, drives the next cycle's inputs, updates the model for the coming
    // edge, and then advances one clock.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic st,
                         input logic fl, input logic rs);
        bit acc, drn;
        chk("in_ready", {63'd0, in_ready_o}, {63'd0, occ != 2});
        chk("out_valid", {63'd0, out_valid_o}, {63'd0, occ != 0});
        chk("stall_cnt", 64'(stall_cnt_o), STATS ? 64'(s_exp) : 64'd0);
        chk("flush_cnt", 64'(flush_cnt_o), STATS ? 64'(f_exp) : 64'd0);
        in_valid_i = v;
        pc_i       = pc;
        inst_i     = inst_of(pc);
        stall_i    = st;
        flush_i    = fl;
        rst_i      = rs;
        acc = v && (occ != 2) && !fl && !rs;
        drn = (occ != 0) && !st;
        if (rs) begin
            s_exp = 0;
            f_exp = 0;
        end else begin
            if (occ != 0 && st) s_exp = (s_exp == CMAX) ? CMAX : s_exp + 1;
            if (fl)             f_exp = (f_exp == CMAX) ? CMAX : f_exp + 1;
        end
        if (rs || fl) begin
            exp_q.delete();
            occ = 0;
        end else begin
            if (acc) exp_q.push_back({pc, inst_of(pc)});
            occ = occ + int'(acc) - int'(drn);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: at negedge, inputs and outputs are both stable for the coming edge.
    always @(negedge clk) begin
        logic [63:0] e;
        if (mon_en) begin
            if (out_valid_o && !stall_i && !flush_i && !rst_i) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output: got pc 0x%0h, expected no entry", pc_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", 64'(pc_o), 64'(e[63:32]));
                    chk("sb_inst", 64'(inst_o), 64'(e[31:0]));
                end
            end else if (!out_valid_o) begin
                chk("bubble_pc", 64'(pc_o), 64'd0);
                chk("bubble_inst", 64'(inst_o), 64'(NOP));
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, {63'd0, out_valid_o}, 64'd0);
        chk({tag, "_pc"}, 64'(pc_o), 64'd0);
        chk({tag, "_inst"}, 64'(inst_o), 64'(NOP));
        chk({tag, "_ready"}, {63'd0, in_ready_o}, 64'd1);
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
        in_valid_i = 1'b0; pc_i = '0; inst_i = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        occ = 0; s_exp = 0; f_exp = 0;
        // Test 1: reset state
        chk_reset_state("rst");
        chk("rst_stall_cnt", 64'(stall_cnt_o), 64'd0);
        chk("rst_flush_cnt", 64'(flush_cnt_o), 64'd0);
        mon_en = 1'b1;

        // Test 2: unstalled stream, 1-cycle latency
        cycle(1, 32'h00, 0, 0, 0); chk("t2_pc0", 64'(pc_o), 64'h00);
        cycle(1, 32'h04, 0, 0, 0); chk("t2_pc1", 64'(pc_o), 64'h04);
        cycle(1, 32'h08, 0, 0, 0); chk("t2_pc2", 64'(pc_o), 64'h08);
        chk("t2_ready", {63'd0, in_ready_o}, 64'd1);
        cycle(0, 32'h0, 0, 0, 0);

        // Test 3: stall while BUSY fills the skid, release drains in order
        cycle(1, 32'h10, 0, 0, 0);
        cycle(1, 32'h14, 1, 0, 0);
        chk("t3_full_ready", {63'd0, in_ready_o}, 64'd0);
        chk("t3_hold_pc", 64'(pc_o), 64'h10);
        cycle(0, 32'h0, 1, 0, 0); chk("t3_hold2_pc", 64'(pc_o), 64'h10);
        cycle(0, 32'h0, 0, 0, 0); chk("t3_next_pc", 64'(pc_o), 64'h14);
        cycle(0, 32'h0, 0, 0, 0); chk("t3_empty", {63'd0, out_valid_o}, 64'd0);

        // Test 4: flush from FULL drops main, skid and the offered entry
        cycle(1, 32'h20, 1, 0, 0);
        cycle(1, 32'h24, 1, 0, 0);
        cycle(1, 32'h28, 1, 1, 0);
        chk_reset_state("t4_flush");
        cycle(1, 32'h2C, 0, 1, 0);            // flush while EMPTY: offer dropped
        chk("t4_flush_empty", {63'd0, out_valid_o}, 64'd0);
        cycle(1, 32'h30, 1, 0, 0);            // stall in EMPTY still loads
        chk("t4_stall_load", 64'(pc_o), 64'h30);
        cycle(0, 32'h0, 0, 0, 0);
        cycle(0, 32'h0, 0, 0, 0);

        // Test 5: reset + flush + valid in FULL
        cycle(1, 32'h50, 1, 0, 0);
        cycle(1, 32'h54, 1, 0, 0);
        cycle(1, 32'h58, 1, 1, 1);
        chk_reset_state("t5_rst");
        chk("t5_stall_cnt", 64'(stall_cnt_o), 64'd0);
        chk("t5_flush_cnt", 64'(flush_cnt_o), 64'd0);

        // Test 6: stall counter saturation, flush counter
        cycle(1, 32'h60, 1, 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 32'h0, 1, 0, 0);
        chk("t6_stall_sat", 64'(stall_cnt_o), STATS ? 64'(CMAX) : 64'd0);
        for (int i = 0; i < 3; i++) cycle(0, 32'h0, 0, 1, 0);
        chk("t6_flush_cnt", 64'(flush_cnt_o), STATS ? 64'd3 : 64'd0);

        // Mixed stream with intermittent stalls
        for (int i = 0; i < 10; i++)
            cycle(1, 32'h100 + 32'(4 * i), (i % 3) == 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 32'h0, 0, 0, 0);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
